// File: rtl/v_pkg.sv
// Shared vector-unit definitions: issue FSM state encoding and the VALU/VMEM
// opcode constants used by both the decoder and the issue controller.
package v_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEC   = 3'd1,
    ST_DIV   = 3'd2,
    ST_MEM   = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB_LO = 3'd5,
    ST_WB_HI = 3'd6
  } state_e;

  localparam logic [4:0] VALU_OP_NOP    = 5'd0;
  localparam logic [4:0] VALU_OP_VADD16 = 5'd1;
  localparam logic [4:0] VALU_OP_VSUB16 = 5'd2;
  localparam logic [4:0] VALU_OP_VDIV16 = 5'd3;
  localparam logic [4:0] VALU_OP_VMUL16 = 5'd4;
  localparam logic [4:0] VALU_OP_VADD32 = 5'd5;
  localparam logic [4:0] VALU_OP_VSUB32 = 5'd6;
  localparam logic [4:0] VALU_OP_VDIV32 = 5'd7;

  localparam logic [6:0] VALU_OP_MAJOR  = 7'b1010111;
  localparam logic [6:0] VMEM_OP_LOAD   = 7'b0000111;
  localparam logic [6:0] VMEM_OP_STORE  = 7'b0100111;

endpackage

// File: rtl/v_issue_ctrl.sv
// Vector issue sequencer: latches one instruction from the core and walks it
// through decode, divide / memory access and one or two writeback beats.
module v_issue_ctrl
  import v_pkg::*;
#(
  parameter int INST_DW   = 32,
  parameter int VREG_AW   = 5,
  parameter int VALUOP_DW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid_i,
  input  logic [INST_DW-1:0]   inst_i,
  output logic                 inst_ready_o,
  output logic [INST_DW-1:0]   inst_o,
  input  logic                 dec_vmem_ren_i,
  input  logic                 dec_vmem_wen_i,
  input  logic [VALUOP_DW-1:0] dec_valu_opcode_i,
  input  logic                 dec_wb_en_i,
  input  logic                 dec_wb_double_i,
  input  logic [VREG_AW-1:0]   dec_wb_addr_i,
  output logic                 valu_start_o,
  input  logic                 valu_done_i,
  output logic                 vmem_req_o,
  input  logic                 vmem_gnt_i,
  input  logic                 vmem_rvalid_i,
  output logic                 vreg_wen_o,
  output logic [VREG_AW-1:0]   vreg_waddr_o,
  output logic                 vreg_whi_o,
  output logic                 busy_o
);

  state_e               state_q, state_d;
  logic [INST_DW-1:0]   inst_q, inst_d;
  logic [VREG_AW-1:0]   vd_q, vd_d;
  logic                 load_q, load_d;
  logic                 dbl_q, dbl_d;
  logic                 div_first_q, div_first_d;
  logic                 is_div;
  logic                 act;

  assign is_div = (dec_valu_opcode_i == VALUOP_DW'(VALU_OP_VDIV16)) ||
                  (dec_valu_opcode_i == VALUOP_DW'(VALU_OP_VDIV32));

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    vd_d        = vd_q;
    load_d      = load_q;
    dbl_d       = dbl_q;
    div_first_d = div_first_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid_i) begin
          inst_d  = inst_i;
          state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        load_d      = dec_vmem_ren_i;
        dbl_d       = dec_wb_double_i;
        vd_d        = dec_wb_addr_i;
        div_first_d = 1'b0;
        if (dec_vmem_ren_i || dec_vmem_wen_i) begin
          state_d = ST_MEM;
        end else if (is_div) begin
          state_d     = ST_DIV;
          div_first_d = 1'b1;
        end else if (dec_wb_en_i) begin
          state_d = ST_WB_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        div_first_d = 1'b0;
        if (valu_done_i) state_d = ST_WB_LO;
      end
      // Load data arriving together with the grant skips the wait state.
      ST_MEM: begin
        if (vmem_gnt_i) begin
          if (!load_q)            state_d = ST_IDLE;
          else if (vmem_rvalid_i) state_d = ST_WB_LO;
          else                    state_d = ST_MWAIT;
        end
      end
      ST_MWAIT: begin
        if (vmem_rvalid_i) state_d = ST_WB_LO;
      end
      ST_WB_LO: state_d = dbl_q ? ST_WB_HI : ST_IDLE;
      ST_WB_HI: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inst_q      <= '0;
      vd_q        <= '0;
      load_q      <= 1'b0;
      dbl_q       <= 1'b0;
      div_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      vd_q        <= vd_d;
      load_q      <= load_d;
      dbl_q       <= dbl_d;
      div_first_q <= div_first_d;
    end
  end

  // Outputs decode the registered state; reset forces them quiet in the same cycle.
  assign act          = !rst;
  assign inst_ready_o = act && (state_q == ST_IDLE);
  assign busy_o       = act && (state_q != ST_IDLE);
  assign inst_o       = act ? inst_q : '0;
  assign valu_start_o = act && (state_q == ST_DIV) && div_first_q;
  assign vmem_req_o   = act && (state_q == ST_MEM);
  assign vreg_wen_o   = act && ((state_q == ST_WB_LO) || (state_q == ST_WB_HI));
  assign vreg_whi_o   = act && (state_q == ST_WB_HI);

  always_comb begin
    vreg_waddr_o = '0;
    if (act && (state_q == ST_WB_LO)) vreg_waddr_o = vd_q;
    if (act && (state_q == ST_WB_HI)) vreg_waddr_o = vd_q + VREG_AW'(1);
  end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Randomized bench for v_issue_ctrl: a stub decoder feeds the dec_* inputs and
// a cycle-timeline model predicts every output per transaction.
module tb_v_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        inst_ready_o;
  logic [31:0] inst_o;
  logic        dec_vmem_ren_i, dec_vmem_wen_i;
  logic [4:0]  dec_valu_opcode_i;
  logic        dec_wb_en_i, dec_wb_double_i;
  logic [4:0]  dec_wb_addr_i;
  logic        valu_start_o, valu_done_i;
  logic        vmem_req_o, vmem_gnt_i, vmem_rvalid_i;
  logic        vreg_wen_o;
  logic [4:0]  vreg_waddr_o;
  logic        vreg_whi_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int C_ALU = 0, C_DIV = 1, C_LOAD = 2, C_STORE = 3, C_NOP = 4;

  always #5 clk = ~clk;

  v_issue_ctrl #(.INST_DW(32), .VREG_AW(5), .VALUOP_DW(5)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_ready_o(inst_ready_o),
    .inst_o(inst_o),
    .dec_vmem_ren_i(dec_vmem_ren_i), .dec_vmem_wen_i(dec_vmem_wen_i),
    .dec_valu_opcode_i(dec_valu_opcode_i),
    .dec_wb_en_i(dec_wb_en_i), .dec_wb_double_i(dec_wb_double_i),
    .dec_wb_addr_i(dec_wb_addr_i),
    .valu_start_o(valu_start_o), .valu_done_i(valu_done_i),
    .vmem_req_o(vmem_req_o), .vmem_gnt_i(vmem_gnt_i), .vmem_rvalid_i(vmem_rvalid_i),
    .vreg_wen_o(vreg_wen_o), .vreg_waddr_o(vreg_waddr_o), .vreg_whi_o(vreg_whi_o),
    .busy_o(busy_o)
  );

  // Stand-in for v_inst_decode, driven from the latched instruction.
  always_comb begin
    dec_vmem_ren_i    = 1'b0;
    dec_vmem_wen_i    = 1'b0;
    dec_valu_opcode_i = 5'd0;
    dec_wb_en_i       = 1'b0;
    dec_wb_double_i   = 1'b0;
    dec_wb_addr_i     = inst_o[11:7];
    case (inst_o[6:0])
      7'b1010111: begin
        dec_valu_opcode_i = inst_o[29:25];
        dec_wb_en_i       = 1'b1;
        dec_wb_double_i   = inst_o[31];
      end
      7'b0000111: begin
        dec_vmem_ren_i  = 1'b1;
        dec_wb_en_i     = 1'b1;
        dec_wb_double_i = (inst_o[14:12] == 3'b001);
      end
      7'b0100111: dec_vmem_wen_i = 1'b1;
      default: ;
    endcase
  end

  function automatic logic [31:0] make_inst(input int cls, input logic [4:0] vd, input logic dbl);
    logic [4:0]  op;
    logic [31:0] rnd;
    rnd = $urandom;
    case (cls)
      C_ALU: begin
        op = 5'($urandom_range(0, 6));
        if (op == 5'd3) op = 5'd5;
        return {dbl, 1'b0, op, rnd[9:0], 3'b000, vd, 7'b1010111};
      end
      C_DIV: begin
        op = rnd[20] ? 5'd7 : 5'd3;
        return {dbl, 1'b0, op, rnd[9:0], 3'b000, vd, 7'b1010111};
      end
      C_LOAD:  return {rnd[16:0], 2'b00, dbl, vd, 7'b0000111};
      C_STORE: return {rnd[16:0], 3'b000, rnd[21:17], 7'b0100111};
      default: return {rnd[24:0], 7'b0000000};
    endcase
  endfunction

  // Drives one instruction from accept (cycle 0) to the cycle it is IDLE again,
  // predicting every output from the class and the handshake delays.
  task automatic run_txn(input string nm, input logic [31:0] inst, input int cls,
                         input logic [4:0] vd, input logic dbl,
                         input int g, input int r, input int dd);
    int wb0, last;
    bit is_mem, wb_dbl;
    logic [10:0] obs, exp;
    logic e_rdy, e_req, e_st, e_wen, e_whi, e_busy;
    logic [4:0] e_addr;
    is_mem = (cls == C_LOAD) || (cls == C_STORE);
    wb_dbl = dbl && (cls != C_STORE) && (cls != C_NOP);
    case (cls)
      C_ALU:   wb0 = 2;
      C_DIV:   wb0 = 3 + dd;
      C_LOAD:  wb0 = 3 + g + r;
      default: wb0 = -10;
    endcase
    if (cls == C_NOP)        last = 2;
    else if (cls == C_STORE) last = 3 + g;
    else                     last = wb0 + 1 + (wb_dbl ? 1 : 0);
    for (int c = 0; c <= last; c++) begin
      inst_valid_i  = (c == 0);
      inst_i        = inst;
      valu_done_i   = (cls == C_DIV) && (c == 2 + dd);
      vmem_gnt_i    = is_mem && (c == 2 + g);
      vmem_rvalid_i = (cls == C_LOAD) ? (c == 2 + g + r) : (!is_mem && $urandom_range(0, 1) == 1);
      @(negedge clk);
      e_rdy  = (c == 0) || (c == last);
      e_busy = (c >= 1) && (c < last);
      e_req  = is_mem && (c >= 2) && (c <= 2 + g);
      e_st   = (cls == C_DIV) && (c == 2);
      e_whi  = wb_dbl && (c == wb0 + 1);
      e_wen  = (c == wb0) || e_whi;
      e_addr = (c == wb0) ? vd : (e_whi ? 5'((int'(vd) + 1) % 32) : 5'd0);
      exp = {e_rdy, e_req, e_st, e_wen, e_whi, e_busy, e_addr};
      obs = {inst_ready_o, vmem_req_o, valu_start_o, vreg_wen_o, vreg_whi_o, busy_o, vreg_waddr_o};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d {rdy,req,start,wen,whi,busy,addr} got=%b required=%b", nm, c, obs, exp);
      end
      if (c >= 1) begin
        n_cmp++;
        if (inst_o !== inst) begin
          n_bad++;
          $display("FAIL %s_inst_o cyc=%0d got=%h required=%h", nm, c, inst_o, inst);
        end
      end
      @(posedge clk); #1;
    end
    inst_valid_i = 1'b0; valu_done_i = 1'b0; vmem_gnt_i = 1'b0; vmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_valid_i = 1'b1; inst_i = 32'hdead_beef;
    valu_done_i = 1'b0; vmem_gnt_i = 1'b0; vmem_rvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({inst_ready_o, busy_o, vmem_req_o, valu_start_o, vreg_wen_o, vreg_whi_o, vreg_waddr_o, inst_o} !== 43'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b busy=%b inst_o=%h required all 0", inst_ready_o, busy_o, inst_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; inst_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({inst_ready_o, busy_o, inst_o} !== {1'b1, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_release got rdy=%b busy=%b inst_o=%h required 1 0 0", inst_ready_o, busy_o, inst_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    run_txn("vadd32", {2'b00, 5'd5, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1010111}, C_ALU, 5'd4, 1'b0, 0, 0, 0);
    run_txn("alu_dbl", make_inst(C_ALU, 5'd31, 1'b1), C_ALU, 5'd31, 1'b1, 0, 0, 0);
  endtask

  task automatic test_div();
    run_txn("vdiv16", {2'b00, 5'd3, 5'd6, 5'd7, 3'b000, 5'd9, 7'b1010111}, C_DIV, 5'd9, 1'b0, 0, 0, 5);
    run_txn("vdiv32_same_cyc_done", {2'b10, 5'd7, 10'd0, 3'b000, 5'd12, 7'b1010111}, C_DIV, 5'd12, 1'b1, 0, 0, 0);
  endtask

  task automatic test_load();
    run_txn("load_dbl_wrap", {17'd0, 3'b001, 5'd31, 7'b0000111}, C_LOAD, 5'd31, 1'b1, 3, 2, 0);
    run_txn("load_gnt_rvalid", {17'd0, 3'b001, 5'd6, 7'b0000111}, C_LOAD, 5'd6, 1'b1, 0, 0, 0);
  endtask

  task automatic test_store();
    run_txn("store_gnt4", {25'h1234, 7'b0100111}, C_STORE, 5'd0, 1'b0, 4, 0, 0);
    run_txn("store_imm", {25'h0, 7'b0100111}, C_STORE, 5'd0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_nop();
    run_txn("nop", {25'h155_5555, 7'b0000000}, C_NOP, 5'd0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset_mwait();
    logic [31:0] nop2;
    nop2 = {25'h0ab_cdef, 7'b0000000};
    inst_valid_i = 1'b1; inst_i = {17'd0, 3'b000, 5'd7, 7'b0000111};
    @(posedge clk); #1;
    inst_valid_i = 1'b0;
    @(posedge clk); #1;
    vmem_gnt_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vmem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rstm_req got=%b required=1", vmem_req_o);
    end
    @(posedge clk); #1;
    vmem_gnt_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, vmem_req_o, vreg_wen_o} !== 3'b100) begin
      n_bad++; $display("FAIL rstm_mwait got={busy,req,wen}=%b required=100", {busy_o, vmem_req_o, vreg_wen_o});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({inst_ready_o, busy_o, vmem_req_o, vreg_wen_o, vreg_waddr_o} !== 9'd0) begin
      n_bad++; $display("FAIL rstm_during got rdy=%b busy=%b wen=%b required all 0", inst_ready_o, busy_o, vreg_wen_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; vmem_rvalid_i = 1'b1; inst_valid_i = 1'b1; inst_i = nop2;
    @(negedge clk);
    n_cmp++;
    if ({inst_ready_o, busy_o, vreg_wen_o, inst_o} !== {3'b100, 32'd0}) begin
      n_bad++; $display("FAIL rstm_after got rdy=%b busy=%b wen=%b inst_o=%h required 1 0 0 0", inst_ready_o, busy_o, vreg_wen_o, inst_o);
    end
    @(posedge clk); #1;
    vmem_rvalid_i = 1'b0; inst_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, vreg_wen_o, inst_o} !== {2'b10, nop2}) begin
      n_bad++; $display("FAIL rstm_accept got busy=%b wen=%b inst_o=%h required 1 0 %h", busy_o, vreg_wen_o, inst_o, nop2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({inst_ready_o, busy_o} !== 2'b10) begin
      n_bad++; $display("FAIL rstm_idle got rdy=%b busy=%b required 1 0", inst_ready_o, busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    inst_valid_i = 1'b1; inst_i = {25'h0f0f0f0, 7'b0000000};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({inst_ready_o, busy_o, vreg_wen_o} !== {(c % 2 == 0), (c % 2 == 1), 1'b0}) begin
        n_bad++; $display("FAIL b2b cyc=%0d got rdy=%b busy=%b wen=%b required rdy=%0d", c, inst_ready_o, busy_o, vreg_wen_o, (c % 2 == 0));
      end
      @(posedge clk); #1;
    end
    inst_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cls, g, r, dd;
    logic [4:0] vd;
    logic dbl;
    for (int k = 0; k < 40; k++) begin
      cls = $urandom_range(0, 4);
      vd  = 5'($urandom);
      dbl = 1'($urandom);
      g   = $urandom_range(0, 4);
      r   = $urandom_range(0, 4);
      dd  = $urandom_range(0, 5);
      if (cls == C_STORE || cls == C_NOP) vd = 5'd0;
      run_txn($sformatf("rand%0d_c%0d", k, cls), make_inst(cls, vd, dbl), cls, vd, dbl, g, r, dd);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_div();
    test_load();
    test_store();
    test_nop();
    test_reset_mwait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
